// File: rtl/mem_port_arbiter.sv
// Round-robin owner arbitration for the shared 16-bit memory port, with a hold
// limit so a contested owner is rotated out after MAX_HOLD cycles.

module mem_port_lane #(
   parameter int DATA_WIDTH = 16
) (
   input  logic                  gnt,
   input  logic [DATA_WIDTH-1:0] data,
   output logic [DATA_WIDTH-1:0] word
);
   assign word = gnt ? data : '0;
endmodule

module mem_port_arbiter #(
   parameter int DATA_WIDTH = 16,
   parameter int MAX_HOLD   = 8
) (
   input  logic                    i_clk,
   input  logic                    i_reset,
   input  logic [3:0]              i_req,
   input  logic [4*DATA_WIDTH-1:0] i_data,
   output logic [3:0]              o_gnt,
   output logic [1:0]              o_sel,
   output logic                    o_valid,
   output logic [DATA_WIDTH-1:0]   o_data
);
   localparam int         NUM_LANES = 4;
   localparam logic [7:0] HOLD_MAX  = 8'(MAX_HOLD);

   typedef enum logic {IDLE, OWN} state_t;

   state_t     state_q, state_n;
   logic [3:0] gnt_q, gnt_n;
   logic [1:0] sel_q, sel_n;
   logic       valid_q, valid_n;
   logic [1:0] ptr_q, ptr_n;
   logic [7:0] hold_q, hold_n;

   logic [2:0] pick_rr, pick_pre;
   logic       do_grant;
   logic [1:0] win;

   // Returns {found, index}: first requester with its bit set, scanning from base.
   function automatic logic [2:0] rr_pick(input logic [1:0] base, input logic [3:0] req);
      logic       found;
      logic [1:0] idx, sel;
      found = 1'b0;
      sel   = 2'd0;
      for (int i = 0; i < NUM_LANES; i++) begin
         idx = base + 2'(i);
         if (!found && req[idx]) begin
            found = 1'b1;
            sel   = idx;
         end
      end
      return {found, sel};
   endfunction

   assign pick_rr  = rr_pick(ptr_q, i_req);
   // Preemption never hands the port back to the current owner.
   assign pick_pre = rr_pick(sel_q + 2'd1, i_req & ~(4'b0001 << sel_q));

   always_comb begin
      state_n  = state_q;
      gnt_n    = gnt_q;
      sel_n    = sel_q;
      valid_n  = valid_q;
      ptr_n    = ptr_q;
      hold_n   = hold_q;
      do_grant = 1'b0;
      win      = 2'd0;
      case (state_q)
         IDLE: begin
            if (pick_rr[2]) begin
               do_grant = 1'b1;
               win      = pick_rr[1:0];
            end
         end
         OWN: begin
            if (!i_req[sel_q]) begin
               if (pick_rr[2]) begin
                  do_grant = 1'b1;
                  win      = pick_rr[1:0];
               end else begin
                  state_n = IDLE;
                  gnt_n   = 4'b0000;
                  valid_n = 1'b0;
               end
            end else if (hold_q >= HOLD_MAX && pick_pre[2]) begin
               do_grant = 1'b1;
               win      = pick_pre[1:0];
            end else if (hold_q < HOLD_MAX) begin
               hold_n = hold_q + 8'd1;
            end
         end
         default: state_n = IDLE;
      endcase
      if (do_grant) begin
         state_n = OWN;
         gnt_n   = 4'b0001 << win;
         sel_n   = win;
         valid_n = 1'b1;
         hold_n  = 8'd1;
         ptr_n   = win + 2'd1;
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_q <= IDLE;
         gnt_q   <= 4'b0000;
         sel_q   <= 2'd0;
         valid_q <= 1'b0;
         ptr_q   <= 2'd0;
         hold_q  <= 8'd0;
      end else begin
         state_q <= state_n;
         gnt_q   <= gnt_n;
         sel_q   <= sel_n;
         valid_q <= valid_n;
         ptr_q   <= ptr_n;
         hold_q  <= hold_n;
      end
   end

   // One-hot grant masks each lane, so OR-ing lanes equals the o_sel mux.
   logic [NUM_LANES-1:0][DATA_WIDTH-1:0] lane_word;

   for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
      mem_port_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
         .gnt  (gnt_q[k]),
         .data (i_data[k*DATA_WIDTH +: DATA_WIDTH]),
         .word (lane_word[k])
      );
   end

   always_comb begin
      o_data = '0;
      for (int k = 0; k < NUM_LANES; k++) o_data = o_data | lane_word[k];
   end

   assign o_gnt   = gnt_q;
   assign o_sel   = sel_q;
   assign o_valid = valid_q;
endmodule
